// File: rtl/mac_pkg.sv
// Shared constants and stage payload types for the MAC normalise/round datapath.
// Bit indices refer to the magnitude after left-normalising its leading one to the MSB.
package mac_pkg;

   localparam int ACC_W  = 18;
   localparam int EXP_W  = 6;
   localparam int MAN_W  = 2;
   localparam int LD_POS = 13;

   localparam int E_W   = EXP_W + 2;
   localparam int POS_W = $clog2(ACC_W);

   localparam int MAN_HI    = ACC_W - 2;
   localparam int MAN_LO    = ACC_W - 1 - MAN_W;
   localparam int GUARD_IDX = MAN_LO - 1;
   localparam int ROUND_IDX = MAN_LO - 2;
   localparam int STICKY_HI = MAN_LO - 3;

   localparam int SAT_EXP = (1 << EXP_W) - 1;

   typedef struct packed {
      logic             sign;
      logic [ACC_W-1:0] mag;
      logic [EXP_W-1:0] exp;
   } s1_t;

   typedef struct packed {
      logic             sign;
      logic             zero;
      logic [MAN_W-1:0] man;
      logic             guard;
      logic             rnd;
      logic             sticky;
      logic [E_W-1:0]   e;
   } s2_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
      logic             zero;
      logic             ovf;
      logic             uf;
   } res_t;

endpackage

// File: rtl/lead_one_detect.sv
// Combinational leading-one detector: index of the most significant set bit of vec.
// pos reads 0 when vec is all zeros; zero flags that case.
module lead_one_detect #(
   parameter int W = 18
) (
   input  logic [W-1:0]         vec,
   output logic [$clog2(W)-1:0] pos,
   output logic                 zero
);

   localparam int PW = $clog2(W);

   always_comb begin
      pos = '0;
      for (int i = 0; i < W; i++) begin
         if (vec[i]) pos = PW'(i);
      end
   end

   assign zero = ~|vec;

endmodule

// File: rtl/normalize_round_pp_sum.sv
// Converts a two's-complement partial-product sum into sign/exponent/mantissa with
// round-to-nearest-even, in a 3-stage valid/ready pipeline (abs -> normalise -> round).
module normalize_round_pp_sum
   import mac_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ACC_W-1:0] acc_sum,
   input  logic [EXP_W-1:0] max_exp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [MAN_W-1:0] out_man,
   output logic             out_zero,
   output logic             out_ovf,
   output logic             out_uf
);

   localparam logic signed [E_W-1:0] SAT_EXP_S = E_W'(SAT_EXP);

   logic v1, v2, v3;
   logic ld1, ld2, ld3;
   s1_t  s1_q, s1_d;
   s2_t  s2_q, s2_d;
   res_t s3_q, s3_d;

   // A stage may load when it is empty or its contents move on this cycle.
   assign ld3      = !v3 || out_ready;
   assign ld2      = !v2 || ld3;
   assign ld1      = !v1 || ld2;
   assign in_ready = ld1;

   always_comb begin
      s1_d      = '0;
      s1_d.sign = acc_sum[ACC_W-1];
      s1_d.mag  = acc_sum[ACC_W-1] ? (~acc_sum + 1'b1) : acc_sum;
      s1_d.exp  = max_exp;
   end

   logic [POS_W-1:0] lod_pos;
   logic             lod_zero;
   logic [ACC_W-1:0] norm;

   lead_one_detect #(.W(ACC_W)) u_lod (
      .vec  (s1_q.mag),
      .pos  (lod_pos),
      .zero (lod_zero)
   );

   // Shifting the leading one to the MSB makes every bit below weight 2^0 read as zero.
   assign norm = s1_q.mag << (POS_W'(ACC_W - 1) - lod_pos);

   always_comb begin
      s2_d        = '0;
      s2_d.sign   = s1_q.sign;
      s2_d.zero   = lod_zero;
      s2_d.man    = norm[MAN_HI:MAN_LO];
      s2_d.guard  = norm[GUARD_IDX];
      s2_d.rnd    = norm[ROUND_IDX];
      s2_d.sticky = |norm[STICKY_HI:0];
      s2_d.e      = E_W'(s1_q.exp) + E_W'(lod_pos) - E_W'(LD_POS);
   end

   logic                  rnd_up;
   logic                  carry;
   logic [MAN_W-1:0]      man_rnd;
   logic signed [E_W-1:0] e_s2;
   logic signed [E_W-1:0] e_rnd;

   always_comb begin
      rnd_up           = s2_q.guard & (s2_q.rnd | s2_q.sticky | s2_q.man[0]);
      {carry, man_rnd} = {1'b0, s2_q.man} + {{MAN_W{1'b0}}, rnd_up};
      e_s2             = s2_q.e;
      e_rnd            = e_s2 + $signed({{(E_W-1){1'b0}}, carry});

      s3_d = '0;
      if (s2_q.zero) begin
         s3_d.zero = 1'b1;
      end else if (e_rnd < 0) begin
         s3_d.uf   = 1'b1;
         s3_d.zero = 1'b1;
      end else if (e_rnd > SAT_EXP_S) begin
         s3_d.ovf  = 1'b1;
         s3_d.sign = s2_q.sign;
         s3_d.exp  = '1;
         s3_d.man  = '1;
      end else begin
         s3_d.sign = s2_q.sign;
         s3_d.exp  = e_rnd[EXP_W-1:0];
         s3_d.man  = man_rnd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         v3   <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         if (ld1) begin
            v1   <= in_valid;
            s1_q <= s1_d;
         end
         if (ld2) begin
            v2   <= v1;
            s2_q <= s2_d;
         end
         if (ld3) begin
            v3   <= v2;
            s3_q <= s3_d;
         end
      end
   end

   assign out_valid = v3;
   assign out_sign  = s3_q.sign;
   assign out_exp   = s3_q.exp;
   assign out_man   = s3_q.man;
   assign out_zero  = s3_q.zero;
   assign out_ovf   = s3_q.ovf;
   assign out_uf    = s3_q.uf;

endmodule

// File: tb/tb_normalize_round_pp_sum.sv
// Scoreboard bench for normalize_round_pp_sum: expected results are computed from an
// arithmetic model at input transfer and compared in order as outputs are accepted.
module tb_normalize_round_pp_sum;

   typedef struct packed {
      logic       sign;
      logic [5:0] exp;
      logic [1:0] man;
      logic       zero;
      logic       ovf;
      logic       uf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] acc_sum;
   logic [5:0]  max_exp;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic [5:0]  out_exp;
   logic [1:0]  out_man;
   logic        out_zero;
   logic        out_ovf;
   logic        out_uf;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_out    = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   normalize_round_pp_sum dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .acc_sum   (acc_sum),
      .max_exp   (max_exp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_exp   (out_exp),
      .out_man   (out_man),
      .out_zero  (out_zero),
      .out_ovf   (out_ovf),
      .out_uf    (out_uf)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic exp_t model(input logic [17:0] a, input logic [5:0] me);
      exp_t        r;
      int          mag, p, m, g, rb, st, up, e;
      logic [31:0] n;
      r   = '0;
      mag = a[17] ? (1 << 18) - int'(a) : int'(a);
      if (mag == 0) begin
         r.zero = 1'b1;
         return r;
      end
      p = 0;
      for (int i = 0; i < 18; i++) if (((mag >> i) & 1) == 1) p = i;
      n  = 32'(mag) << (24 - p);
      m  = int'(n[23:22]);
      g  = int'(n[21]);
      rb = int'(n[20]);
      st = int'(|n[19:0]);
      e  = int'(me) + p - 13;
      up = g & (rb | st | (m & 1));
      m  = m + up;
      if (m == 4) begin
         m = 0;
         e = e + 1;
      end
      if (e > 63) begin
         r.ovf = 1'b1; r.sign = a[17]; r.exp = 6'h3f; r.man = 2'b11;
      end else if (e < 0) begin
         r.uf = 1'b1; r.zero = 1'b1;
      end else begin
         r.sign = a[17]; r.exp = 6'(e); r.man = 2'(m);
      end
      return r;
   endfunction

   task automatic cmp_out(input string tag, input exp_t w);
      check_val({tag, "_sign"}, 32'(out_sign), 32'(w.sign));
      check_val({tag, "_exp"},  32'(out_exp),  32'(w.exp));
      check_val({tag, "_man"},  32'(out_man),  32'(w.man));
      check_val({tag, "_zero"}, 32'(out_zero), 32'(w.zero));
      check_val({tag, "_ovf"},  32'(out_ovf),  32'(w.ovf));
      check_val({tag, "_uf"},   32'(out_uf),   32'(w.uf));
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check_val("unexpected_out", 32'(1), 32'(0));
         end else begin
            cmp_out("out", sb[0]);
            void'(sb.pop_front());
            n_out++;
         end
      end
   end

   task automatic send(input logic [17:0] a, input logic [5:0] me);
      bit ok = 1'b0;
      in_valid = 1'b1;
      acc_sum  = a;
      max_exp  = me;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_val("send_timeout", 32'(0), 32'(1));
      else sb.push_back(model(a, me));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 300 && sb.size() > 0; t++) @(posedge clk);
      if (sb.size() > 0) check_val("drain_timeout", 32'(sb.size()), 32'(0));
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int   lat;
      int   base;
      logic rnd_done;
      logic [17:0] ra;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      acc_sum   = '0;
      max_exp   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid", 32'(out_valid), 32'(0));
      check_val("rst_out_data", {24'd0, out_sign, out_exp, out_man}, 32'(0));
      check_val("rst_out_flags", {29'd0, out_zero, out_ovf, out_uf}, 32'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_in_ready", 32'(in_ready), 32'(1));

      // latency of a single entry through an empty pipe
      lat = 0;
      fork
         send(18'h02000, 6'd20);
         forever begin
            @(posedge clk);
            lat++;
         end
      join_any
      disable fork;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         lat++;
      end
      check_val("latency", 32'(lat), 32'(3));
      drain();

      send(18'h3C800, 6'd20);
      send(18'h03C00, 6'd20);
      send(18'h02C00, 6'd20);
      send(18'h10000, 6'd62);
      send(18'h00001, 6'd5);
      send(18'h00000, 6'd17);
      send(18'h20000, 6'd10);
      send(18'h1FFFF, 6'd0);
      drain();

      // back-pressure: three accepted, fourth stalls, output held
      out_ready = 1'b0;
      base = n_out;
      send(18'h02400, 6'd30);
      send(18'h3E000, 6'd31);
      send(18'h02A00, 6'd32);
      @(negedge clk);
      check_val("bp_in_ready_full", 32'(in_ready), 32'(0));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_val("bp_out_valid", 32'(out_valid), 32'(1));
         if (sb.size() > 0) cmp_out("bp_hold", sb[0]);
      end
      fork
         send(18'h01B00, 6'd33);
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check_val("bp_count", 32'(n_out - base), 32'(4));

      // randomised stimulus under random back-pressure
      rnd_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 24; k++) begin
               ra = 18'($urandom) >> $urandom_range(0, 17);
               send(ra, 6'($urandom_range(0, 63)));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();

      // reset with two entries in flight
      send(18'h02000, 6'd12);
      send(18'h03000, 6'd13);
      rst_n = 1'b0;
      #1;
      check_val("midrst_out_valid", 32'(out_valid), 32'(0));
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      base = n_out;
      repeat (8) @(posedge clk);
      #1;
      check_val("midrst_no_emit", 32'(n_out - base), 32'(0));
      check_val("midrst_out_valid_after", 32'(out_valid), 32'(0));
      check_val("midrst_in_ready", 32'(in_ready), 32'(1));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
